// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the FSM state enum, forward selects and the forwarding compare helper.
package pipeline_hazard_ctrl_pkg;

    localparam int REG_W = 5;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        MEM_ERR  = 2'd2
    } hz_state_t;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_EM = 2'b01;
    localparam logic [1:0] FWD_WB = 2'b10;

    // EM wins over MW; x0 is hardwired zero and is never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_W-1:0] rs,
        input logic [REG_W-1:0] em_rd,
        input logic             em_we,
        input logic [REG_W-1:0] mw_rd,
        input logic             mw_we
    );
        if (em_we && em_rd != '0 && em_rd == rs)
            return FWD_EM;
        else if (mw_we && mw_rd != '0 && mw_rd == rs)
            return FWD_WB;
        else
            return FWD_RF;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_fwd_unit.sv
// EX-stage operand forwarding compare (purely combinational).
// Ports: DE rs1/rs2, EM/MW rd + write enables in; fwd_a/fwd_b selects out.
module pipeline_fwd_unit
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] de_rs1,
    input  logic [REG_W-1:0] de_rs2,
    input  logic [REG_W-1:0] em_rd,
    input  logic             em_reg_write,
    input  logic [REG_W-1:0] mw_rd,
    input  logic             mw_reg_write,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b
);

    assign fwd_a = fwd_sel(de_rs1, em_rd, em_reg_write, mw_rd, mw_reg_write);
    assign fwd_b = fwd_sel(de_rs2, em_rd, em_reg_write, mw_rd, mw_reg_write);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// 5-stage pipeline sequencing: stalls, flushes, forwarding, memory wait FSM.
// Ports: hazard/regfile indices and mem handshake in; stall/flush/fwd, error, perf counters out.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [REG_W-1:0] d_rs1_i,
    input  logic [REG_W-1:0] d_rs2_i,
    input  logic             d_uses_rs1_i,
    input  logic             d_uses_rs2_i,
    input  logic [REG_W-1:0] de_rs1_i,
    input  logic [REG_W-1:0] de_rs2_i,
    input  logic [REG_W-1:0] de_rd_i,
    input  logic             de_mem_read_i,
    input  logic [REG_W-1:0] em_rd_i,
    input  logic             em_reg_write_i,
    input  logic [REG_W-1:0] mw_rd_i,
    input  logic             mw_reg_write_i,
    input  logic             em_pc_select_i,
    input  logic             mem_req_i,
    input  logic             mem_ack_i,
    output logic             stall_f_o,
    output logic             stall_d_o,
    output logic             stall_e_o,
    output logic             stall_m_o,
    output logic             flush_d_o,
    output logic             flush_e_o,
    output logic             flush_m_o,
    output logic             flush_w_o,
    output logic [1:0]       fwd_a_o,
    output logic [1:0]       fwd_b_o,
    output logic             mem_err_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam int WCW = 16;
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(MEM_TIMEOUT - 1);

    hz_state_t      state;
    logic [WCW-1:0] wait_cnt;
    logic           load_use;
    logic           freeze;

    pipeline_fwd_unit u_fwd (
        .de_rs1       (de_rs1_i),
        .de_rs2       (de_rs2_i),
        .em_rd        (em_rd_i),
        .em_reg_write (em_reg_write_i),
        .mw_rd        (mw_rd_i),
        .mw_reg_write (mw_reg_write_i),
        .fwd_a        (fwd_a_o),
        .fwd_b        (fwd_b_o)
    );

    assign load_use = de_mem_read_i && (de_rd_i != '0) &&
                      ((d_uses_rs1_i && d_rs1_i == de_rd_i) ||
                       (d_uses_rs2_i && d_rs2_i == de_rd_i));

    // An ack in the request cycle never freezes; MEM_ERR freezes forever.
    assign freeze = (state == RUN      && mem_req_i && !mem_ack_i) ||
                    (state == MEM_WAIT && !mem_ack_i) ||
                    (state == MEM_ERR);

    always_comb begin
        stall_f_o = 1'b0;
        stall_d_o = 1'b0;
        stall_e_o = 1'b0;
        stall_m_o = 1'b0;
        flush_d_o = 1'b0;
        flush_e_o = 1'b0;
        flush_m_o = 1'b0;
        flush_w_o = 1'b0;
        if (freeze) begin
            // Upstream held; MW drains so a stale writeback never repeats.
            stall_f_o = 1'b1;
            stall_d_o = 1'b1;
            stall_e_o = 1'b1;
            stall_m_o = 1'b1;
            flush_w_o = 1'b1;
        end else if (em_pc_select_i) begin
            // Load-use consumer is on the wrong path, so it is dropped.
            flush_d_o = 1'b1;
            flush_e_o = 1'b1;
            flush_m_o = 1'b1;
        end else if (load_use) begin
            stall_f_o = 1'b1;
            stall_d_o = 1'b1;
            flush_e_o = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state       <= RUN;
            wait_cnt    <= '0;
            mem_err_o   <= 1'b0;
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            unique case (state)
                RUN: begin
                    if (mem_req_i && !mem_ack_i) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= WCW'(1);
                    end
                end
                MEM_WAIT: begin
                    if (mem_ack_i) begin
                        state    <= RUN;
                        wait_cnt <= '0;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state     <= MEM_ERR;
                        mem_err_o <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WCW'(1);
                    end
                end
                MEM_ERR: begin
                    state <= MEM_ERR;
                end
                default: begin
                    state <= RUN;
                end
            endcase
            if (stall_f_o && stall_cnt_o != '1)
                stall_cnt_o <= stall_cnt_o + CNT_W'(1);
            if (flush_m_o && flush_cnt_o != '1)
                flush_cnt_o <= flush_cnt_o + CNT_W'(1);
        end
    end

endmodule
